// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, bus widths,
// the default ready-transition timeout and the latched request payload.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MASK_W = 2;
  localparam int unsigned TMO_W  = 8;

  // Default number of cycles allowed for each ready transition.
  localparam logic [TMO_W-1:0] TIMEOUT_DEFAULT = 8'd255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } state_e;

  // Request captured at arbitration and presented to the controller.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [MASK_W-1:0] wtbt;
    logic              we;
  } mem_req_t;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on clk_i.
//   clk_i     : destination clock
//   arst_n_i  : raw asynchronous active-low reset
//   rst_n_o   : reset with synchronised release
module reset_sync (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU, video) round-robin arbiter in front of an SDRAM controller
// that uses a rd/we rising-edge + ready low/high handshake.
//   clk_sdram, init_n           : clock, async active-low reset
//   cpu_addr/din/wtbt/rd/we     : CPU level request, held until cpu_ack
//   cpu_dout, cpu_ack           : CPU read data, one-cycle completion pulse
//   vid_addr, vid_rd            : video read request, held until vid_ack
//   vid_dout, vid_ack           : video read data, one-cycle completion pulse
//   mem_addr/din/wtbt/rd/we     : request toward the controller
//   mem_dout, mem_ready         : controller read data and ready
//   err                         : sticky ready-transition timeout flag
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_sdram,
  input  logic              init_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [MASK_W-1:0] cpu_wtbt,
  input  logic              cpu_rd,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_rd,
  output logic [DATA_W-1:0] vid_dout,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [MASK_W-1:0] mem_wtbt,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ready,
  output logic              err
);

  logic rst_n;

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;
  logic              owner_vid_q, owner_vid_d;
  logic              prio_vid_q, prio_vid_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] vid_dout_q, vid_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic cpu_req_c;
  logic any_req_c;
  logic vid_win_c;
  logic tmo_hit_c;

  // Assertion of init_n is immediate; only its release is synchronised.
  reset_sync u_reset_sync (
    .clk_i    (clk_sdram),
    .arst_n_i (init_n),
    .rst_n_o  (rst_n)
  );

  // Arbitration helpers: video wins ties when it holds the priority token.
  assign cpu_req_c = cpu_rd | cpu_we;
  assign any_req_c = cpu_req_c | vid_rd;
  assign vid_win_c = vid_rd & (~cpu_req_c | prio_vid_q);
  assign tmo_hit_c = (tmo_q == (TIMEOUT - TMO_W'(1)));

  // State register.
  always_ff @(posedge clk_sdram or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. IDLE waits on mem_ready with no timeout, which also
  // covers controller startup.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_ready && any_req_c) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!mem_ready) begin
          state_d = WAIT_HIGH;
        end else if (tmo_hit_c) begin
          state_d = GAP;
        end
      end
      WAIT_HIGH: begin
        if (mem_ready || tmo_hit_c) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    req_d       = req_q;
    mem_rd_d    = mem_rd_q;
    mem_we_d    = mem_we_q;
    owner_vid_d = owner_vid_q;
    prio_vid_d  = prio_vid_q;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    err_d       = err_q;
    tmo_d       = tmo_q;

    case (state_q)
      IDLE: begin
        if (mem_ready && any_req_c) begin
          owner_vid_d = vid_win_c;
          // The loser of this grant gets priority next time.
          prio_vid_d  = ~vid_win_c;
          if (vid_win_c) begin
            req_d.addr = vid_addr;
            req_d.wtbt = '0;
            req_d.we   = 1'b0;
            mem_rd_d   = 1'b1;
            mem_we_d   = 1'b0;
          end else begin
            // rd+we together is a write.
            req_d.addr = cpu_addr;
            req_d.din  = cpu_din;
            req_d.wtbt = cpu_wtbt;
            req_d.we   = cpu_we;
            mem_rd_d   = ~cpu_we;
            mem_we_d   = cpu_we;
          end
        end
      end

      ISSUE: begin
        tmo_d = '0;
      end

      WAIT_LOW: begin
        // Strobe held until the controller signals it has taken the access.
        if (!mem_ready) begin
          mem_rd_d = 1'b0;
          mem_we_d = 1'b0;
          tmo_d    = '0;
        end else if (tmo_hit_c) begin
          mem_rd_d  = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          cpu_ack_d = ~owner_vid_q;
          vid_ack_d = owner_vid_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WAIT_HIGH: begin
        mem_rd_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_ready) begin
          cpu_ack_d = ~owner_vid_q;
          vid_ack_d = owner_vid_q;
          if (!req_q.we) begin
            if (owner_vid_q) begin
              vid_dout_d = mem_dout;
            end else begin
              cpu_dout_d = mem_dout;
            end
          end
        end else if (tmo_hit_c) begin
          // Timed-out access is acked but leaves *_dout untouched.
          err_d     = 1'b1;
          cpu_ack_d = ~owner_vid_q;
          vid_ack_d = owner_vid_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      GAP: begin
        mem_rd_d = 1'b0;
        mem_we_d = 1'b0;
      end

      default: begin
        mem_rd_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_sdram or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      owner_vid_q <= 1'b0;
      prio_vid_q  <= 1'b1;
      cpu_dout_q  <= '0;
      vid_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      req_q       <= req_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      owner_vid_q <= owner_vid_d;
      prio_vid_q  <= prio_vid_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_addr = req_q.addr;
  assign mem_din  = req_q.din;
  assign mem_wtbt = req_q.wtbt;
  assign mem_rd   = mem_rd_q;
  assign mem_we   = mem_we_q;
  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign vid_dout = vid_dout_q;
  assign vid_ack  = vid_ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural ready/data controller.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk_sdram = 1'b0;
  logic        init_n    = 1'b1;
  logic [23:0] cpu_addr  = '0;
  logic [15:0] cpu_din   = '0;
  logic [1:0]  cpu_wtbt  = '0;
  logic        cpu_rd    = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic [23:0] vid_addr  = '0;
  logic        vid_rd    = 1'b0;
  logic [15:0] vid_dout;
  logic        vid_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wtbt;
  logic        mem_rd;
  logic        mem_we;
  logic [15:0] mem_dout  = '0;
  logic        mem_ready = 1'b0;
  logic        err;

  sram_arbiter dut (
    .clk_sdram (clk_sdram),
    .init_n    (init_n),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_wtbt  (cpu_wtbt),
    .cpu_rd    (cpu_rd),
    .cpu_we    (cpu_we),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .vid_addr  (vid_addr),
    .vid_rd    (vid_rd),
    .vid_dout  (vid_dout),
    .vid_ack   (vid_ack),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wtbt  (mem_wtbt),
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready),
    .err       (err)
  );

  always #5 clk_sdram = ~clk_sdram;

  localparam int TMO = int'(TIMEOUT_DEFAULT);

  typedef struct {
    logic        is_vid;
    logic        is_wr;
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
    logic [15:0] cpu_dout;
    logic [15:0] vid_dout;
    logic        err;
    int          lat;
    int          alen;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Controller model knobs.
  logic ctl_started = 1'b0;
  logic never_drop  = 1'b0;
  int   drop_dly    = 1;
  int   busy        = 6;

  // Expected state tracked in completion order.
  logic [15:0] exp_cpu_last = '0;
  logic [15:0] exp_vid_last = '0;
  logic        exp_err      = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [23:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // Controller model: ready drops drop_dly cycles after a strobe rise and
  // returns busy cycles later; read data is a function of the address.
  int   k = 100000;
  logic act_prev_m = 1'b0;
  always @(negedge clk_sdram) begin
    logic act;
    act = mem_rd | mem_we;
    if (act && !act_prev_m) begin
      k = 0;
      mem_dout = mdata(mem_addr);
    end else if (k < 100000) begin
      k++;
    end
    act_prev_m = act;
    if (!ctl_started)    mem_ready = 1'b0;
    else if (never_drop) mem_ready = 1'b1;
    else                 mem_ready = !(k >= drop_dly && k < drop_dly + busy);
  end

  // Monitor: checks issue against the scoreboard head, strobe width, and
  // pops/compares on every ack.
  int   cyc = 0;
  int   issue_cyc = 0;
  logic act_prev = 1'b0;
  logic ack_prev = 1'b0;
  always @(negedge clk_sdram) begin
    logic act;
    exp_t e;
    cyc++;
    act = mem_rd | mem_we;
    if (act && !act_prev) begin
      issue_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 32'(act), 32'(0));
      end else begin
        e = exp_q[0];
        check("issue_addr", 32'(mem_addr), 32'(e.addr));
        check("issue_rd", 32'(mem_rd), 32'(!e.is_wr));
        check("issue_we", 32'(mem_we), 32'(e.is_wr));
        if (e.is_wr) begin
          check("issue_din", 32'(mem_din), 32'(e.din));
          check("issue_wtbt", 32'(mem_wtbt), 32'(e.wtbt));
        end
      end
    end
    if (!act && act_prev && exp_q.size() > 0) begin
      check("strobe_len", 32'(cyc - issue_cyc), 32'(exp_q[0].alen));
    end
    if (cpu_ack || vid_ack) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(cpu_ack | vid_ack), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_vid", 32'(vid_ack), 32'(e.is_vid));
        check("ack_cpu", 32'(cpu_ack), 32'(!e.is_vid));
        check("ack_cpu_dout", 32'(cpu_dout), 32'(e.cpu_dout));
        check("ack_vid_dout", 32'(vid_dout), 32'(e.vid_dout));
        check("ack_err", 32'(err), 32'(e.err));
        check("ack_latency", 32'(cyc - issue_cyc), 32'(e.lat));
      end
    end
    if (ack_prev) begin
      check("ack_pulse", 32'(cpu_ack | vid_ack), 32'(0));
    end
    ack_prev = cpu_ack | vid_ack;
    act_prev = act;
  end

  task automatic push(input logic is_vid, input logic is_wr, input logic [23:0] addr,
                      input logic [15:0] din, input logic [1:0] wtbt);
    exp_t e;
    if (!is_wr && !never_drop) begin
      if (is_vid) exp_vid_last = mdata(addr);
      else        exp_cpu_last = mdata(addr);
    end
    if (never_drop) exp_err = 1'b1;
    e.is_vid   = is_vid;
    e.is_wr    = is_wr;
    e.addr     = addr;
    e.din      = din;
    e.wtbt     = wtbt;
    e.cpu_dout = exp_cpu_last;
    e.vid_dout = exp_vid_last;
    e.err      = exp_err;
    e.lat      = never_drop ? TMO + 1 : drop_dly + busy + 1;
    e.alen     = never_drop ? TMO + 1 : drop_dly + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge clk_sdram);
      t++;
      if (cpu_ack || vid_ack) got++;
    end
    check("ack_count", 32'(got), 32'(n));
  endtask

  task automatic cpu_access(input logic wr, input logic both, input logic [23:0] addr,
                            input logic [15:0] din, input logic [1:0] wtbt, input int budget);
    push(1'b0, wr, addr, din, wtbt);
    cpu_addr = addr;
    cpu_din  = din;
    cpu_wtbt = wtbt;
    cpu_we   = wr;
    cpu_rd   = !wr || both;
    wait_acks(1, budget);
    cpu_rd = 1'b0;
    cpu_we = 1'b0;
    repeat (3) @(negedge clk_sdram);
  endtask

  task automatic vid_access(input logic [23:0] addr, input int budget);
    push(1'b1, 1'b0, addr, '0, '0);
    vid_addr = addr;
    vid_rd   = 1'b1;
    wait_acks(1, budget);
    vid_rd = 1'b0;
    repeat (3) @(negedge clk_sdram);
  endtask

  task automatic reset_dut();
    @(negedge clk_sdram);
    init_n = 1'b0;
    repeat (3) @(negedge clk_sdram);
    init_n = 1'b1;
    repeat (3) @(negedge clk_sdram);
    exp_q.delete();
    exp_cpu_last = '0;
    exp_vid_last = '0;
    exp_err      = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_strobe;
    logic saw_err;
    logic saw_ack;
    logic seen;

    // Let the synchroniser settle, then apply a real reset edge.
    repeat (3) @(negedge clk_sdram);
    init_n = 1'b0;
    repeat (2) @(negedge clk_sdram);
    check("rst_mem_rd", 32'(mem_rd), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rst_vid_ack", 32'(vid_ack), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_cpu_dout", 32'(cpu_dout), 32'(0));
    check("rst_vid_dout", 32'(vid_dout), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    init_n = 1'b1;
    repeat (3) @(negedge clk_sdram);

    // Controller not ready after reset: request waits, no strobe, no error.
    drop_dly = 1; busy = 6;
    push(1'b0, 1'b0, 24'h000042, '0, '0);
    cpu_addr = 24'h000042;
    cpu_rd   = 1'b1;
    saw_strobe = 1'b0;
    saw_err    = 1'b0;
    repeat (100) begin
      @(negedge clk_sdram);
      saw_strobe |= mem_rd | mem_we;
      saw_err    |= err;
    end
    check("startup_no_strobe", 32'(saw_strobe), 32'(0));
    check("startup_no_err", 32'(saw_err), 32'(0));
    ctl_started = 1'b1;
    wait_acks(1, 50);
    cpu_rd = 1'b0;
    repeat (3) @(negedge clk_sdram);

    // Single CPU read returning A5C3.
    cpu_access(1'b0, 1'b0, 24'h000000, '0, '0, 50);
    // CPU write, then a rd+we write; cpu_dout must not move.
    cpu_access(1'b1, 1'b0, 24'h000100, 16'h1234, 2'b01, 50);
    cpu_access(1'b1, 1'b1, 24'h000200, 16'hBEEF, 2'b11, 50);
    // Video read, then a CPU read with different controller timing.
    vid_access(24'h00ABCD, 50);
    drop_dly = 3; busy = 2;
    @(negedge clk_sdram);
    cpu_access(1'b0, 1'b0, 24'h123456, '0, '0, 50);

    // Simultaneous held requests after reset: video, cpu, video, cpu.
    reset_dut();
    drop_dly = 2; busy = 3;
    @(negedge clk_sdram);
    push(1'b1, 1'b0, 24'h200022, '0, '0);
    push(1'b0, 1'b0, 24'h000011, '0, '0);
    push(1'b1, 1'b0, 24'h200022, '0, '0);
    push(1'b0, 1'b0, 24'h000011, '0, '0);
    cpu_addr = 24'h000011;
    vid_addr = 24'h200022;
    cpu_rd   = 1'b1;
    vid_rd   = 1'b1;
    wait_acks(4, 200);
    cpu_rd = 1'b0;
    vid_rd = 1'b0;
    repeat (10) @(negedge clk_sdram);
    check("rr_drained", 32'(exp_q.size()), 32'(0));

    // Ready never drops: timeout, err set, ack with dout unchanged.
    never_drop = 1'b1;
    @(negedge clk_sdram);
    cpu_access(1'b0, 1'b0, 24'h000777, '0, '0, TMO + 100);
    check("tmo_err_sticky", 32'(err), 32'(1));
    never_drop = 1'b0;
    drop_dly = 1; busy = 4;
    @(negedge clk_sdram);
    vid_access(24'h000888, 50);

    // Reset pulsed in WAIT_HIGH: no ack, IDLE, err cleared.
    drop_dly = 1; busy = 20;
    @(negedge clk_sdram);
    push(1'b0, 1'b0, 24'h000999, '0, '0);
    cpu_addr = 24'h000999;
    cpu_rd   = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk_sdram);
      seen = mem_rd;
    end
    check("abort_issue_seen", 32'(seen), 32'(1));
    repeat (3) @(negedge clk_sdram);
    #2 init_n = 1'b0;
    #1;
    check("abort_mem_rd", 32'(mem_rd), 32'(0));
    check("abort_mem_we", 32'(mem_we), 32'(0));
    check("abort_cpu_ack", 32'(cpu_ack), 32'(0));
    check("abort_err", 32'(err), 32'(0));
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    cpu_rd = 1'b0;
    exp_q.delete();
    exp_cpu_last = '0;
    exp_vid_last = '0;
    exp_err      = 1'b0;
    repeat (2) @(negedge clk_sdram);
    init_n = 1'b1;
    saw_ack = 1'b0;
    repeat (40) begin
      @(negedge clk_sdram);
      saw_ack |= cpu_ack | vid_ack;
    end
    check("abort_no_ack", 32'(saw_ack), 32'(0));

    // Normal access after the aborted one.
    drop_dly = 2; busy = 2;
    @(negedge clk_sdram);
    cpu_access(1'b0, 1'b0, 24'h000555, '0, '0, 50);
    check("final_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, max cycles to wait for each ready transition before flagging an error.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clk_sdram  in  1  sole clock; same clock as the SDRAM controller.
- init_n  in  1  reset; asynchronous, active-low.
- cpu_addr  in  24  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_wtbt  in  2  CPU write byte mask.
- cpu_rd  in  1  level request; held until cpu_ack.
- cpu_we  in  1  level request; held until cpu_ack.
- cpu_dout  out  16  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_addr  in  24  video fetch address.
- vid_rd  in  1  level request; held until vid_ack.
- vid_dout  out  16  video read data.
- vid_ack  out  1  one-cycle completion pulse.
- mem_addr  out  24  to controller addr.
- mem_din  out  16  to controller din.
- mem_wtbt  out  2  to controller wtbt.
- mem_rd  out  1  to controller rd.
- mem_we  out  1  to controller we.
- mem_dout  in  16  from controller dout.
- mem_ready  in  1  from controller ready.
- err  out  1  sticky timeout flag.

Function
REQ-003 All outputs SHALL be registered; reset values are 0 for all.
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP.
REQ-005 IDLE: when mem_ready=1 and a request is pending, the FSM SHALL latch the winner's addr, data, mask and direction into mem_* and go to ISSUE.
REQ-006 Arbitration SHALL be round-robin: a single requester always wins; when both request, the port not served last wins; after reset, video wins.
REQ-007 cpu_we=cpu_rd=1 together SHALL be treated as a write.
REQ-008 ISSUE: mem_rd or mem_we SHALL be 1 (rising edge toward the controller); the FSM SHALL go to WAIT_LOW.
REQ-009 WAIT_LOW: mem_rd/mem_we SHALL stay 1 until mem_ready=0 is sampled, then go to WAIT_HIGH.
REQ-010 WAIT_HIGH: on sampling mem_ready=1, the FSM SHALL:
- drop mem_rd/mem_we;
- for reads, copy mem_dout into the winner's *_dout;
- pulse the winner's *_ack for exactly one cycle;
- go to GAP.
REQ-011 GAP SHALL last one cycle with mem_rd=mem_we=0, guaranteeing a falling edge between accesses, then return to IDLE.
REQ-012 *_dout SHALL hold its value until that port's next read completes; writes SHALL NOT change *_dout.
REQ-013 A requester SHALL drop its request the cycle after *_ack; a request still high in the cycle after ack SHALL be treated as a new request.
REQ-014 Requests changing while not owned SHALL be ignored until IDLE arbitration.
REQ-015 The minimum access is ISSUE->ack in 3 cycles; back-to-back throughput is limited by controller ready.
REQ-016 A timeout counter SHALL reset on entry to WAIT_LOW and to WAIT_HIGH. If it reaches TIMEOUT in either state, the FSM SHALL:
- set err;
- drop mem_rd/mem_we;
- pulse the winner's ack with *_dout unchanged;
- go to GAP.
REQ-017 err SHALL clear only on reset.
REQ-018 Before the controller first raises mem_ready (startup), requests SHALL wait in IDLE indefinitely without timeout.

Reset
REQ-019 Asserting init_n=0 SHALL immediately, at any state including mid-access, force:
- FSM=IDLE, mem_rd=mem_we=0, acks=0;
- round-robin pointer=video, err=0, timeout counter=0.
REQ-020 An access interrupted by reset SHALL NOT be acked.
REQ-021 Release of init_n SHALL be synchronised to clk_sdram before use.

Structure
REQ-022 A shared package SHALL hold the FSM state enumeration and the TIMEOUT default; the package is reused by the controller testbench.
REQ-023 The design SHALL be a single module with no sub-modules; an optional 2-flop reset synchroniser sub-module is named reset_sync.

Verification
REQ-024 Single CPU read, ready model dropping 1 cycle after rd rise and rising 6 cycles later with mem_dout=16'hA5C3 -> cpu_dout=16'hA5C3, one cpu_ack pulse, mem_rd high exactly until ready seen low.
REQ-025 CPU write, addr 24'h000100, din 16'h1234, wtbt 2'b01 -> mem_* carry those values during ISSUE; cpu_ack after ready rises; cpu_dout unchanged.
REQ-026 cpu_rd and vid_rd raised in the same cycle, held after ack, for 4 accesses -> grant order video, cpu, video, cpu.
REQ-027 Ready model never drops -> err=1 and ack after TIMEOUT cycles in WAIT_LOW; a subsequent normal access still completes.
REQ-028 mem_ready=0 for 100 cycles after reset with cpu_rd=1 -> no mem_rd and no err; access proceeds once ready=1.
REQ-029 init_n pulsed low while in WAIT_HIGH -> mem_rd=0 immediately, no ack, FSM in IDLE, err=0.
